data_sram_resp: RTL and testbench
=================================

// Module: data_sram_resp
// PURPOSE
//  Data-SRAM responder: the far end of the EX-stage data_sram_* request interface.
//  Byte-lane writes, one-hot load-type tagged reads, LAT-cycle fixed read latency.
//  Returns load data already byte/half selected and sign/zero extended for MEM/WB.
//  No backpressure: one request is accepted every cycle that data_sram_en=1.
// PARAMETERS
//  AW   14  word-index bits; storage = 2**AW x 32-bit words (64 KiB at default)
//  LAT  1   read latency in cycles, legal 1..4; checked at elaboration
// PORTS
//  clk            in   1   single clock, all state on posedge
//  resetn         in   1   asynchronous, active-low reset
//  data_sram_en   in   1   request valid
//  data_sram_wen  in   4   byte-lane write enables; 0 = read
//  data_sram_addr in   32  byte address
//  data_sram_wdata in  32  write data, already lane-replicated by requester
//  load_type      in   5   one-hot {lb,lh,lw,lbu,lhu}, `LOAD_SRAM_DATA_WD
//  resp_valid     out  1   read data valid, exactly LAT cycles after accept
//  resp_rdata     out  32  extended load result
//  resp_err       out  1   with resp_valid: misaligned read
//  wr_err         out  1   1-cycle pulse: illegal write, suppressed
// BEHAVIOUR
//  Index = addr[AW+1:2]; addr[31:AW+2] ignored (aliasing wrap, no fault).
//  Write (en & wen!=0): at posedge mem[idx] lane i <= wdata[8i+7:8i] where wen[i].
//   Legal wen: 0001,0010,0100,1000,0011,1100,1111; 1111 requires addr[1:0]=00,
//   0011/1100 require addr[0]=0. Else no lane written, wr_err=1 next cycle.
//   Writes never generate resp_valid.
//  Read (en & wen==0): word fetched at accept edge; {addr[1:0],load_type} carried
//   down LAT-deep shift pipe (valid bit per stage); stage LAT drives outputs.
//  Read-after-write: write at edge N, read accepted at edge N+1 sees new data.
//   A read and write cannot share a cycle (single request port).
//  Extension at output stage (sub-module): lb/lbu byte = addr[1:0] lane, sign/zero;
//   lh/lhu half = addr[1] ? [31:16] : [15:0], sign/zero; lw or load_type==0 -> word.
//  Misalign: lw & addr[1:0]!=0, lh/lhu & addr[0]=1 -> resp_err=1, resp_rdata=0.
//  load_type not one-hot (>1 bit) -> treated as lw, resp_err=1.
//  Back-to-back reads fully pipelined: throughput 1/cycle for any LAT.
//  Reset (resetn=0, async): pipe valids, resp_valid, resp_rdata, resp_err, wr_err
//   all 0 immediately; in-flight reads dropped, never returned. Memory array not
//   reset (contents undefined until written).
//  en=0 with other inputs toggling: no state change.
// STRUCTURE
//  defines.vh: LOAD_SRAM_DATA_WD, one-hot bit positions LD_LB..LD_LHU, legal wen
//   codes as localparam constants.
//  Sub-module load_ext: comb {word, addr[1:0], load_type} -> {rdata, err}.
//  Top: storage array, write-legality check, LAT-stage read pipe, output regs.
// TESTING
//  Reset: resetn=0 mid-pipe with 2 reads in flight -> no resp_valid ever appears.
//  sw 0x8000_0000 @0x10, lw @0x10 -> LAT cycles later resp_rdata=0x8000_0000, err=0.
//  sb 0xAB (wdata=0xABABABAB,wen=0100) @0x22 onto 0x11223344 @0x20; lb @0x22 ->
//   0xFFFFFFAB; lbu @0x22 -> 0x000000AB; lw @0x20 -> 0x11AB3344.
//  sh 0x8001 wen=1100 @0x32; lh @0x32 -> 0xFFFF8001; lhu -> 0x00008001;
//   lh @0x31 -> resp_err=1, rdata=0.
//  wen=0110 @0x40 or wen=1111 @0x42 -> wr_err pulse, mem[0x40] unchanged.
//  LAT=3: 8 back-to-back lw to consecutive words -> 8 consecutive resp_valid,
//   in order, first at cycle 3; alias addr 0x0001_0010 (AW=14) reads word @0x10.

Source files
------------

// File: rtl/data_sram_resp_pkg.sv
// data_sram_resp_pkg: load-type encoding, legal byte-enable codes and read-pipe stage type
package data_sram_resp_pkg;
    localparam int LOAD_SRAM_DATA_WD = 5;
    localparam int LD_LB  = 4;
    localparam int LD_LH  = 3;
    localparam int LD_LW  = 2;
    localparam int LD_LBU = 1;
    localparam int LD_LHU = 0;
    localparam logic [3:0] WEN_B0 = 4'b0001;
    localparam logic [3:0] WEN_B1 = 4'b0010;
    localparam logic [3:0] WEN_B2 = 4'b0100;
    localparam logic [3:0] WEN_B3 = 4'b1000;
    localparam logic [3:0] WEN_H0 = 4'b0011;
    localparam logic [3:0] WEN_H1 = 4'b1100;
    localparam logic [3:0] WEN_W  = 4'b1111;

    typedef struct packed {
        logic                         v;
        logic [31:0]                  word;
        logic [1:0]                   off;
        logic [LOAD_SRAM_DATA_WD-1:0] lt;
    } rd_stage_t;

    function automatic logic wen_legal(input logic [3:0] wen, input logic [1:0] off);
        return (wen == WEN_B0) || (wen == WEN_B1) || (wen == WEN_B2) || (wen == WEN_B3)
            || (((wen == WEN_H0) || (wen == WEN_H1)) && !off[0])
            || ((wen == WEN_W) && (off == 2'b00));
    endfunction
endpackage

// File: rtl/data_sram_resp_load_ext.sv
// data_sram_resp_load_ext: selects byte/half/word from a fetched word and sign/zero extends it
module data_sram_resp_load_ext
    import data_sram_resp_pkg::*;
(
    input  logic [31:0]                  word,
    input  logic [1:0]                   off,
    input  logic [LOAD_SRAM_DATA_WD-1:0] lt,
    output logic [31:0]                  rdata,
    output logic                         err
);
    logic       multi, lb, lh, lbu, lhu, lw, mis;
    logic [7:0]  byt;
    logic [15:0] half;

    // decode load type (multi-hot behaves as lw but always flags), then extend
    always_comb begin
        multi = $countones(lt) > 1;
        lb    = !multi && lt[LD_LB];
        lh    = !multi && lt[LD_LH];
        lbu   = !multi && lt[LD_LBU];
        lhu   = !multi && lt[LD_LHU];
        lw    = multi || lt[LD_LW];
        byt   = word[8*off +: 8];
        half  = off[1] ? word[31:16] : word[15:0];
        mis   = (lw && off != 2'b00) || ((lh || lhu) && off[0]);
        err   = multi || mis;
        rdata = mis ? 32'h0 :
                lb  ? {{24{byt[7]}}, byt} :
                lbu ? {24'h0, byt} :
                lh  ? {{16{half[15]}}, half} :
                lhu ? {16'h0, half} : word;
    end
endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: byte-lane SRAM responder with fixed LAT-cycle extended read data
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int AW  = 14,
    parameter int LAT = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         data_sram_en,
    input  logic [3:0]                   data_sram_wen,
    input  logic [31:0]                  data_sram_addr,
    input  logic [31:0]                  data_sram_wdata,
    input  logic [LOAD_SRAM_DATA_WD-1:0] load_type,
    output logic                         resp_valid,
    output logic [31:0]                  resp_rdata,
    output logic                         resp_err,
    output logic                         wr_err
);
    if (LAT < 1 || LAT > 4) begin : g_lat_chk
        $error("data_sram_resp: LAT must be 1..4");
    end

    logic [31:0]   mem [2**AW];
    logic [AW-1:0] idx;
    logic          rd_acc, wr_acc, wr_err_d, wr_err_q, unused_hi;
    rd_stage_t     pipe_d [LAT];
    rd_stage_t     pipe_q [LAT];
    logic [31:0]   ext_rdata;
    logic          ext_err;

    assign unused_hi = ^data_sram_addr[31:AW+2];

    // request decode, word fetch into stage 0, and pipe shift
    always_comb begin
        idx      = data_sram_addr[AW+1:2];
        rd_acc   = data_sram_en && data_sram_wen == 4'b0000;
        wr_acc   = data_sram_en && data_sram_wen != 4'b0000 && wen_legal(data_sram_wen, data_sram_addr[1:0]);
        wr_err_d = data_sram_en && data_sram_wen != 4'b0000 && !wen_legal(data_sram_wen, data_sram_addr[1:0]);
        pipe_d[0] = {rd_acc, mem[idx], data_sram_addr[1:0], load_type};
        for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    // byte-lane writes; storage itself is never reset
    always_ff @(posedge clk) begin
        if (wr_acc)
            for (int i = 0; i < 4; i++)
                if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end

    // read pipe and write-error pulse; reset drops anything in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
            wr_err_q <= 1'b0;
        end else begin
            pipe_q   <= pipe_d;
            wr_err_q <= wr_err_d;
        end
    end

    data_sram_resp_load_ext u_ext (
        .word  (pipe_q[LAT-1].word),
        .off   (pipe_q[LAT-1].off),
        .lt    (pipe_q[LAT-1].lt),
        .rdata (ext_rdata),
        .err   (ext_err)
    );

    assign resp_valid = pipe_q[LAT-1].v;
    assign resp_rdata = pipe_q[LAT-1].v ? ext_rdata : 32'h0;
    assign resp_err   = pipe_q[LAT-1].v && ext_err;
    assign wr_err     = wr_err_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: random and directed checks of data_sram_resp against a behavioural memory model
module tb_data_sram_resp;
    localparam int AW  = 14;
    localparam int LAT = 3;
    localparam logic [4:0] LB = 5'b10000, LH = 5'b01000, LW = 5'b00100, LBU = 5'b00010, LHU = 5'b00001;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;
    logic [4:0]  lt;
    logic        resp_valid, resp_err, wr_err;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    data_sram_resp #(.AW(AW), .LAT(LAT)) dut (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .load_type(lt),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .wr_err(wr_err)
    );

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } exp_t;

    int          n_vec = 0, n_err = 0, cyc = 0, wr_err_due = -1;
    exp_t        q[$];
    logic [31:0] mm [int];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, exp);
        end
    endtask

    function automatic exp_t ref_load(input logic [31:0] w, input logic [1:0] off, input logic [4:0] t, input int due);
        exp_t r;
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        r.due = due;
        r.e = 1'b0;
        r.d = w;
        if ($countones(t) > 1) begin
            r.e = 1'b1;
            r.d = (off == 0) ? w : 32'h0;
        end else if (t == LB) r.d = (b >= 128) ? b - 256 : b;
        else if (t == LBU) r.d = b;
        else if (t == LH || t == LHU) begin
            if (off[0]) begin r.e = 1'b1; r.d = 32'h0; end
            else r.d = (t == LH && h >= 32768) ? h - 65536 : h;
        end else if (t == LW && off != 0) begin
            r.e = 1'b1;
            r.d = 32'h0;
        end
        return r;
    endfunction

    task automatic step(input logic e, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] t);
        int          i;
        logic [31:0] w;
        logic        legal, ev;
        i = int'((a >> 2) & ((32'd1 << AW) - 1));
        en = e; wen = we; addr = a; wdata = wd; lt = t;
        w = mm.exists(i) ? mm[i] : 32'h0;
        if (e && we == 0) q.push_back(ref_load(w, a[1:0], t, cyc + LAT));
        if (e && we != 0) begin
            legal = (we inside {4'd1, 4'd2, 4'd4, 4'd8}) || ((we inside {4'd3, 4'd12}) && !a[0])
                 || (we == 4'd15 && a[1:0] == 0);
            if (legal) begin
                for (int k = 0; k < 4; k++) if (we[k]) w[8*k +: 8] = wd[8*k +: 8];
                mm[i] = w;
            end else wr_err_due = cyc + 1;
        end
        @(negedge clk);
        cyc++;
        ev = q.size() > 0 && q[0].due <= cyc;
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
        if (ev) begin
            chk("resp_rdata", resp_rdata, q[0].d);
            chk("resp_err", {31'b0, resp_err}, {31'b0, q[0].e});
            void'(q.pop_front());
        end
        chk("wr_err", {31'b0, wr_err}, {31'b0, wr_err_due == cyc});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, $urandom, $urandom, $urandom, $urandom);
    endtask

    initial begin
        logic [4:0]  t;
        logic [31:0] a;
        resetn = 1'b0; en = 1'b0; wen = '0; addr = '0; wdata = '0; lt = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'b0, resp_err}, 32'h0);
        chk("rst_wr_err", {31'b0, wr_err}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        step(1, 4'hF, 32'h10, 32'h8000_0000, 0);
        step(1, 0, 32'h10, 0, LW);
        step(1, 4'hF, 32'h20, 32'h1122_3344, 0);
        step(1, 4'b0100, 32'h22, 32'hABAB_ABAB, 0);
        step(1, 0, 32'h22, 0, LB);
        step(1, 0, 32'h22, 0, LBU);
        step(1, 0, 32'h20, 0, LW);
        step(1, 4'b1100, 32'h32, 32'h8001_8001, 0);
        step(1, 0, 32'h32, 0, LH);
        step(1, 0, 32'h32, 0, LHU);
        step(1, 0, 32'h31, 0, LH);
        step(1, 4'hF, 32'h40, 32'h5A5A_5A5A, 0);
        step(1, 4'b0110, 32'h40, 32'hFFFF_FFFF, 0);
        step(1, 4'hF, 32'h42, 32'hFFFF_FFFF, 0);
        step(1, 0, 32'h40, 0, LW);
        step(1, 0, 32'h20, 0, 5'b00110);
        step(1, 0, 32'h21, 0, 5'b00000);
        idle(LAT + 1);
        for (int k = 0; k < 8; k++) step(1, 4'hF, 32'h100 + 4 * k, $urandom, 0);
        for (int k = 0; k < 8; k++) step(1, 0, 32'h100 + 4 * k, 0, LW);
        step(1, 0, 32'h0001_0010, 0, LW);
        idle(LAT + 1);
        step(1, 0, 32'h10, 0, LW);
        step(1, 0, 32'h20, 0, LW);
        en = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, resp_valid}, 32'h0);
        chk("midrst_rdata", resp_rdata, 32'h0);
        chk("midrst_err", {31'b0, resp_err}, 32'h0);
        q.delete();
        @(negedge clk);
        cyc++;
        resetn = 1'b1;
        idle(LAT + 3);
        for (int k = 0; k < 32; k++) step(1, 4'hF, 4 * k, $urandom, 0);
        for (int n = 0; n < 500; n++) begin
            a = ($urandom_range(0, 31) << 2) | ($urandom & 32'h3) | (($urandom & 32'hFFFF) << (AW + 2));
            if ($urandom_range(0, 7) == 0) idle(1);
            else if ($urandom_range(0, 9) < 6) begin
                case ($urandom_range(0, 7))
                    0: t = LB;
                    1: t = LH;
                    2: t = LW;
                    3: t = LBU;
                    4: t = LHU;
                    5: t = 5'b00000;
                    default: t = 5'($urandom);
                endcase
                step(1, 0, a, $urandom, t);
            end else step(1, 4'($urandom_range(1, 15)), a, $urandom, 5'($urandom));
        end
        idle(LAT + 2);
        chk("queue_drained", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
